instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/loader_pkg.sv | 24 ++
 rtl/instr_packer.sv | 26 ++
 rtl/instr_loader.sv | 154 +++++++++++++++
 tb/tb_instr_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, default
// widths and the byte-frame field layout.
package loader_pkg;

  localparam int INSTR_W    = 19;  // instruction word width
  localparam int ADDR_W     = 8;   // instruction-memory address width
  localparam int BYTE_W     = 8;   // width of every frame byte
  localparam int COUNT_W    = 8;   // word-count byte width
  localparam int CSUM_W     = 8;   // checksum byte width
  localparam int B0_FIELD_W = 3;   // low bits of B0 that carry instruction bits
  localparam int B0_PAD_W   = BYTE_W - B0_FIELD_W;  // high bits of B0, must be zero

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    B0,
    B1,
    B2,
    CHECK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/instr_packer.sv
// Packs the three bytes of one frame word into an instruction and flags a
// malformed first byte (any padding bit set).
module instr_packer
  import loader_pkg::*;
#(
  parameter int INSTR_W = loader_pkg::INSTR_W
) (
  input  logic [7:0]         b0,
  input  logic [7:0]         b1,
  input  logic [7:0]         b2,
  output logic [INSTR_W-1:0] word,
  output logic               fmt_err
);

  localparam int PACK_W = B0_FIELD_W + 2 * BYTE_W;

  logic [PACK_W-1:0] packed_word;

  // Word layout: B0 contributes only its low field bits, B1 and B2 are whole.
  always_comb begin
    packed_word = {b0[B0_FIELD_W-1:0], b1, b2};
    word        = INSTR_W'(packed_word);
    fmt_err     = |b0[BYTE_W-1:B0_FIELD_W];
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: receives a count byte, N three-byte words and a
// checksum byte, writes each word to instruction memory and releases the CPU
// only when the whole frame is well formed and its checksum matches.
module instr_loader #(
  parameter int INSTR_W = loader_pkg::INSTR_W,
  parameter int ADDR_W  = loader_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               cpu_run,
  output logic               err
);

  import loader_pkg::*;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   rem_q, rem_d;      // words still expected in this frame
  logic [ADDR_W-1:0]    idx_q, idx_d;      // address of the next word to write
  logic [CSUM_W-1:0]    csum_q, csum_d;    // running XOR of count and payload
  logic [7:0]           b0_q, b0_d;
  logic [7:0]           b1_q, b1_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]   wr_data_q, wr_data_d;

  logic                 accept;
  logic [INSTR_W-1:0]   packed_word;
  logic                 fmt_err;

  // B2 is taken straight from the input so the word is ready the cycle it arrives.
  instr_packer #(
    .INSTR_W (INSTR_W)
  ) u_packer (
    .b0      (b0_q),
    .b1      (b1_q),
    .b2      (in_data),
    .word    (packed_word),
    .fmt_err (fmt_err)
  );

  // Status outputs decode directly from the state so reset clears them at once.
  always_comb begin
    in_ready = (state_q == COUNT) || (state_q == B0) || (state_q == B1) ||
               (state_q == B2) || (state_q == CHECK);
    busy     = in_ready;
    cpu_run  = (state_q == DONE);
    err      = (state_q == ERR);
    accept   = in_valid && in_ready;
    wr_en    = wr_en_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
  end

  // Next-state, datapath and write-strobe logic; every field holds unless a byte is taken.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = COUNT;
          rem_d   = '0;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      COUNT: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data;
          rem_d   = in_data;
          state_d = (in_data == 8'd0) ? ERR : B0;
        end
      end
      B0: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data;
          b0_d    = in_data;
          state_d = B1;
        end
      end
      B1: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data;
          b1_d    = in_data;
          state_d = B2;
        end
      end
      B2: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (fmt_err) begin
            // A malformed word is dropped entirely; earlier words stay written.
            state_d = ERR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = packed_word;
            idx_d     = idx_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            state_d   = (rem_q == 8'd1) ? CHECK : B0;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a frame-position reference model
// predicts every output each cycle; directed frames pin literal results and
// randomized frames with random stalls exercise the rest.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [18:0] wr_data;
  logic        busy;
  logic        cpu_run;
  logic        err;

  instr_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_run  (cpu_run),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame position based) ----------------
  localparam int R_NONE = 0, R_DONE = 1, R_ERR = 2;
  bit          m_active;
  int          m_result;
  int          m_pos;
  int          m_n;
  logic [7:0]  m_csum;
  logic [7:0]  m_w [3];
  bit          m_wr_en;
  logic [7:0]  m_wr_addr;
  logic [18:0] m_wr_data;

  initial begin
    m_active = 0; m_result = R_NONE; m_pos = 0; m_n = 0; m_csum = 0; m_wr_en = 0;
    m_wr_addr = 0; m_wr_data = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_result = R_NONE; m_pos = 0; m_n = 0; m_csum = 0; m_wr_en = 0;
      end else begin
        m_wr_en = 0;
        if (!m_active) begin
          if (start) begin
            m_active = 1; m_pos = 0; m_csum = 0; m_result = R_NONE;
          end
        end else if (in_valid) begin
          if (m_pos == 0) begin
            m_n = in_data; m_csum ^= in_data; m_pos = 1;
            if (in_data == 8'd0) begin m_active = 0; m_result = R_ERR; end
          end else if (m_pos <= 3 * m_n) begin
            int k;
            k = m_pos - 1;
            m_w[k % 3] = in_data;
            m_csum ^= in_data;
            m_pos++;
            if (k % 3 == 2) begin
              if (m_w[0] > 8'd7) begin
                m_active = 0; m_result = R_ERR;
              end else begin
                m_wr_en   = 1;
                m_wr_addr = 8'(k / 3);
                m_wr_data = 19'(m_w[0]) * 19'd65536 + 19'(m_w[1]) * 19'd256 + 19'(m_w[2]);
              end
            end
          end else begin
            m_active = 0;
            m_result = (in_data == m_csum) ? R_DONE : R_ERR;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [7:0]  wlog_addr[$];
  logic [18:0] wlog_data[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {25'd0, in_ready, wr_en, busy, cpu_run, err, |wr_addr, |wr_data}, 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("cpu_run", 32'(cpu_run), 32'(!m_active && m_result == R_DONE));
        chk("err", 32'(err), 32'(!m_active && m_result == R_ERR));
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        if (m_wr_en) begin
          chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
          chk("wr_data", 32'(wr_data), 32'(m_wr_data));
        end
        if (wr_en) begin
          wlog_addr.push_back(wr_addr);
          wlog_data.push_back(wr_data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] frame[$];

  task automatic make_frame(input int n, input int bad_word, input bit bad_cs);
    logic [7:0] cs;
    logic [7:0] b;
    frame.delete();
    cs = 8'(n);
    frame.push_back(8'(n));
    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < 3; j++) begin
        b = 8'($urandom_range(0, 255));
        if (j == 0) b = (w == bad_word) ? (8'h08 | 8'($urandom_range(0, 7)) | (8'($urandom_range(0, 31)) << 3))
                                        : 8'($urandom_range(0, 7));
        frame.push_back(b);
        cs ^= b;
      end
    end
    frame.push_back(bad_cs ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random stalls
  task automatic send_frame(input int mode, input int max_bytes, input int start_at);
    int i;
    bit tog;
    bit v;
    i = 0;
    tog = 1'b1;
    while (i < frame.size() && i < max_bytes) begin
      @(negedge clk); #1;
      if (!m_active) break;
      start = (i == start_at);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = tog;
      else v = ($urandom_range(0, 2) != 0);
      tog = ~tog;
      in_valid = v;
      in_data  = v ? frame[i] : 8'($urandom_range(0, 255));
      if (v) i++;
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-word load
    frame = '{8'h01, 8'h00, 8'h04, 8'h8C, 8'h89};
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, -1);
    chk("s1_nwrites", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() > 0) begin
      chk("s1_addr", 32'(wlog_addr[0]), 32'd0);
      chk("s1_data", 32'(wlog_data[0]), 32'h0048C);
    end
    chk("s1_cpu_run", 32'(cpu_run), 32'd1);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_model_done", 32'(m_result), 32'(R_DONE));

    // Three-word load, in_valid toggling; start from DONE
    make_frame(3, -1, 1'b0);
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    chk("s2_cpu_run_drops", 32'(cpu_run), 32'd0);
    chk("s2_busy", 32'(busy), 32'd1);
    send_frame(1, 99, -1);
    chk("s2_nwrites", 32'(wlog_addr.size()), 32'd3);
    for (int i = 0; i < wlog_addr.size(); i++) chk("s2_addr_order", 32'(wlog_addr[i]), 32'(i));
    chk("s2_cpu_run", 32'(cpu_run), 32'd1);

    // Checksum error
    frame = '{8'h01, 8'h00, 8'h04, 8'h8C, 8'h88};
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, -1);
    chk("s3_nwrites", 32'(wlog_addr.size()), 32'd1);
    chk("s3_err", 32'(err), 32'd1);
    chk("s3_cpu_run", 32'(cpu_run), 32'd0);
    chk("s3_model_err", 32'(m_result), 32'(R_ERR));

    // Count of zero
    frame = '{8'h00, 8'h00};
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, -1);
    chk("s4_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("s4_err", 32'(err), 32'd1);

    // Bad B0 in the first word
    frame = '{8'h01, 8'h08, 8'h12, 8'h34, 8'h17};
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, -1);
    chk("s5_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("s5_err", 32'(err), 32'd1);
    chk("s5_cpu_run", 32'(cpu_run), 32'd0);

    // Reset while B1 of word 1 is awaited
    make_frame(3, -1, 1'b0);
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 5, -1);
    chk("s6_nwrites_before", 32'(wlog_addr.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_outputs", {25'd0, in_ready, wr_en, busy, cpu_run, err, |wr_addr, |wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s6_idle_busy", 32'(busy), 32'd0);
    frame = '{8'h01, 8'h00, 8'h04, 8'h8C, 8'h89};
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, -1);
    chk("s6_reload_nwrites", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() > 0) chk("s6_reload_addr", 32'(wlog_addr[0]), 32'd0);
    chk("s6_cpu_run", 32'(cpu_run), 32'd1);

    // start pulsed during B0 is ignored
    make_frame(2, -1, 1'b0);
    wlog_addr.delete(); wlog_data.delete();
    pulse_start();
    send_frame(0, 99, 1);
    chk("s7_nwrites", 32'(wlog_addr.size()), 32'd2);
    chk("s7_cpu_run", 32'(cpu_run), 32'd1);

    // Randomized frames with random stalls and occasional errors
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 6);
      make_frame(n, ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1,
                 ($urandom_range(0, 7) == 0));
      pulse_start();
      send_frame(2, 99, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3 * n) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
